// File: rtl/mat_mul_host_seq.sv
// mat_mul_host_seq
//
// Host-side sequencer for the mat_mul_system scratchpad command protocol.
// A job is accepted on a valid/ready command port. Its dimensions are checked
// against the systolic array edge. A legal job then drives the second
// SP_BRAM port through a fixed sequence:
//   1. write the descriptor words (ws_os, M, K, N);
//   2. write start=1;
//   3. poll the done word until it reads 1, or until the poll budget runs out;
//   4. clear start, then clear done.
// The result is returned on a valid/ready response port and held until it is
// accepted.
//
// Optional feature, enabled by defining MMH_PERF_CNT_EN:
//   adds output rsp_cycles, the cycles from the start write to done detection
//   inclusive (saturating). It reads 0 for illegal-dimension and timeout
//   responses.
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   cmd_valid/cmd_ready          job handshake (ready only while idle)
//   cmd_ws_os, cmd_m/k/n         dataflow select and GEMM dimensions
//   rsp_valid/rsp_ready          result handshake
//   rsp_status                   00 ok, 01 illegal dims, 10 timeout
//   busy                         high whenever not idle
//   sp_addr/sp_en/sp_we/sp_din   scratchpad port outputs (byte address, word data)
//   sp_dout                      scratchpad read data, one cycle after a read
//   rsp_cycles                   (MMH_PERF_CNT_EN only) job cycle count
module mat_mul_host_seq #(
  parameter int SYS_ARR_SIZE = 8,
  parameter int DIM_W        = 8,
  parameter int POLL_GAP     = 4,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ws_os,
  input  logic [DIM_W-1:0] cmd_m,
  input  logic [DIM_W-1:0] cmd_k,
  input  logic [DIM_W-1:0] cmd_n,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic             busy,
  output logic [31:0]      sp_addr,
  output logic             sp_en,
  output logic [3:0]       sp_we,
  output logic [31:0]      sp_din,
  input  logic [31:0]      sp_dout
`ifdef MMH_PERF_CNT_EN
  ,
  output logic [31:0]      rsp_cycles
`endif
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_MODE   = 4'd1,
    S_WR_M      = 4'd2,
    S_WR_K      = 4'd3,
    S_WR_N      = 4'd4,
    S_WR_START  = 4'd5,
    S_POLL_RD   = 4'd6,
    S_POLL_CHK  = 4'd7,
    S_POLL_GAP  = 4'd8,
    S_CLR_START = 4'd9,
    S_CLR_DONE  = 4'd10,
    S_RESP      = 4'd11
  } state_t;

  localparam logic [31:0] ADDR_START = 32'h0000_0000;
  localparam logic [31:0] ADDR_MODE  = 32'h0000_0004;
  localparam logic [31:0] ADDR_M     = 32'h0000_0008;
  localparam logic [31:0] ADDR_K     = 32'h0000_000C;
  localparam logic [31:0] ADDR_N     = 32'h0000_0010;
  localparam logic [31:0] ADDR_DONE  = 32'h0000_0064;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ILL = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  // Wide enough to hold TIMEOUT_CYC itself.
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  function automatic logic dim_legal(input logic [DIM_W-1:0] d);
    dim_legal = (d != {DIM_W{1'b0}}) && (32'(d) <= 32'(SYS_ARR_SIZE));
  endfunction

  state_t           state_q, state_d;
  logic             ws_os_q, ws_os_d;
  logic [DIM_W-1:0] m_q, m_d, k_q, k_d, n_q, n_d;
  logic [1:0]       status_q, status_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      gap_q, gap_d;

  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic             sp_en_q, sp_en_d;
  logic [3:0]       sp_we_q, sp_we_d;
  logic [31:0]      sp_addr_q, sp_addr_d;
  logic [31:0]      sp_din_q, sp_din_d;

  logic             done_s;
  logic [TMO_W-1:0] tmo_inc_s;
  logic             tmo_hit_s;

  // tmo_inc_s is the number of cycles elapsed since the start write,
  // counted in the current poll cycle.
  assign done_s    = (sp_dout == 32'd1);
  assign tmo_inc_s = tmo_q + TMO_W'(32'd1);
  assign tmo_hit_s = (32'(tmo_inc_s) >= 32'(TIMEOUT_CYC));

  // Next-state, job latch, status and poll/timeout counters.
  always_comb begin
    state_d  = state_q;
    ws_os_d  = ws_os_q;
    m_d      = m_q;
    k_d      = k_q;
    n_d      = n_q;
    status_d = status_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ws_os_d = cmd_ws_os;
          m_d     = cmd_m;
          k_d     = cmd_k;
          n_d     = cmd_n;
          if (dim_legal(cmd_m) && dim_legal(cmd_k) && dim_legal(cmd_n)) begin
            status_d = ST_OK;
            state_d  = S_WR_MODE;
          end else begin
            status_d = ST_ILL;
            state_d  = S_RESP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_MODE: state_d = S_WR_M;
      S_WR_M:    state_d = S_WR_K;
      S_WR_K:    state_d = S_WR_N;
      S_WR_N:    state_d = S_WR_START;
      S_WR_START: begin
        tmo_d   = {TMO_W{1'b0}};
        state_d = S_POLL_RD;
      end
      S_POLL_RD: begin
        tmo_d = tmo_inc_s;
        if (tmo_hit_s) begin
          status_d = ST_TMO;
          state_d  = S_CLR_START;
        end else begin
          state_d = S_POLL_CHK;
        end
      end
      S_POLL_CHK: begin
        tmo_d = tmo_inc_s;
        // A done seen on the timeout cycle still counts as success.
        if (done_s) begin
          state_d = S_CLR_START;
        end else if (tmo_hit_s) begin
          status_d = ST_TMO;
          state_d  = S_CLR_START;
        end else if (POLL_GAP == 0) begin
          state_d = S_POLL_RD;
        end else begin
          gap_d   = 32'(POLL_GAP - 1);
          state_d = S_POLL_GAP;
        end
      end
      S_POLL_GAP: begin
        tmo_d = tmo_inc_s;
        if (tmo_hit_s) begin
          status_d = ST_TMO;
          state_d  = S_CLR_START;
        end else if (gap_q == 32'd0) begin
          state_d = S_POLL_RD;
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end
      S_CLR_START: state_d = S_CLR_DONE;
      S_CLR_DONE:  state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    cmd_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    rsp_valid_d  = (state_d == S_RESP);
    rsp_status_d = 2'b00;
    sp_en_d      = 1'b0;
    sp_we_d      = 4'b0000;
    sp_addr_d    = 32'd0;
    sp_din_d     = 32'd0;
    if (state_d == S_RESP) begin
      rsp_status_d = status_d;
    end else begin
      rsp_status_d = 2'b00;
    end
    case (state_d)
      S_WR_MODE: begin
        sp_en_d   = 1'b1;
        sp_we_d   = 4'b1111;
        sp_addr_d = ADDR_MODE;
        sp_din_d  = {31'd0, ws_os_d};
      end
      S_WR_M: begin
        sp_en_d   = 1'b1;
        sp_we_d   = 4'b1111;
        sp_addr_d = ADDR_M;
        sp_din_d  = 32'(m_d);
      end
      S_WR_K: begin
        sp_en_d   = 1'b1;
        sp_we_d   = 4'b1111;
        sp_addr_d = ADDR_K;
        sp_din_d  = 32'(k_d);
      end
      S_WR_N: begin
        sp_en_d   = 1'b1;
        sp_we_d   = 4'b1111;
        sp_addr_d = ADDR_N;
        sp_din_d  = 32'(n_d);
      end
      // Start goes last so the array never sees a partial descriptor.
      S_WR_START: begin
        sp_en_d   = 1'b1;
        sp_we_d   = 4'b1111;
        sp_addr_d = ADDR_START;
        sp_din_d  = 32'd1;
      end
      S_POLL_RD: begin
        sp_en_d   = 1'b1;
        sp_addr_d = ADDR_DONE;
      end
      S_CLR_START: begin
        sp_en_d   = 1'b1;
        sp_we_d   = 4'b1111;
        sp_addr_d = ADDR_START;
      end
      S_CLR_DONE: begin
        sp_en_d   = 1'b1;
        sp_we_d   = 4'b1111;
        sp_addr_d = ADDR_DONE;
      end
      default: begin
        sp_en_d = 1'b0;
      end
    endcase
  end

  // State, job and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ws_os_q      <= 1'b0;
      m_q          <= {DIM_W{1'b0}};
      k_q          <= {DIM_W{1'b0}};
      n_q          <= {DIM_W{1'b0}};
      status_q     <= 2'b00;
      tmo_q        <= {TMO_W{1'b0}};
      gap_q        <= 32'd0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 2'b00;
      sp_en_q      <= 1'b0;
      sp_we_q      <= 4'b0000;
      sp_addr_q    <= 32'd0;
      sp_din_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      ws_os_q      <= ws_os_d;
      m_q          <= m_d;
      k_q          <= k_d;
      n_q          <= n_d;
      status_q     <= status_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      sp_en_q      <= sp_en_d;
      sp_we_q      <= sp_we_d;
      sp_addr_q    <= sp_addr_d;
      sp_din_q     <= sp_din_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign sp_en      = sp_en_q;
  assign sp_we      = sp_we_q;
  assign sp_addr    = sp_addr_q;
  assign sp_din     = sp_din_q;

`ifdef MMH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  logic [31:0] cyc_q, cyc_d;
  logic [31:0] rsp_cycles_q, rsp_cycles_d;

  // Job cycle counter: the start-write cycle counts as 1, and the value is
  // captured including the cycle that detects done.
  always_comb begin
    cyc_d        = cyc_q;
    rsp_cycles_d = rsp_cycles_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cyc_d        = 32'd0;
          rsp_cycles_d = 32'd0;
        end else begin
          cyc_d = cyc_q;
        end
      end
      S_WR_START: cyc_d = 32'd1;
      S_POLL_RD, S_POLL_GAP: cyc_d = sat_inc(cyc_q);
      S_POLL_CHK: begin
        cyc_d = sat_inc(cyc_q);
        if (done_s) begin
          rsp_cycles_d = sat_inc(cyc_q);
        end else begin
          rsp_cycles_d = rsp_cycles_q;
        end
      end
      default: cyc_d = cyc_q;
    endcase
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q        <= 32'd0;
      rsp_cycles_q <= 32'd0;
    end else begin
      cyc_q        <= cyc_d;
      rsp_cycles_q <= rsp_cycles_d;
    end
  end

  assign rsp_cycles = rsp_cycles_q;
`endif

endmodule

// File: tb/tb_mat_mul_host_seq.sv
// Testbench for mat_mul_host_seq.
// A scratchpad model logs every write and read. The model raises the done
// word a chosen number of cycles after start. A job-level reference model
// predicts the write sequence, status, latency and poll pattern.
module tb_mat_mul_host_seq;
  localparam int SYS_ARR_SIZE = 8;
  localparam int DIM_W        = 8;
  localparam int POLL_GAP     = 4;
  localparam int TIMEOUT_CYC  = 64;
  localparam int SPACING      = POLL_GAP + 2;

  logic             clk       = 1'b0;
  logic             reset_n   = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_ws_os = 1'b0;
  logic [DIM_W-1:0] cmd_m     = 8'd0;
  logic [DIM_W-1:0] cmd_k     = 8'd0;
  logic [DIM_W-1:0] cmd_n     = 8'd0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [1:0]       rsp_status;
  logic             busy;
  logic [31:0]      sp_addr;
  logic             sp_en;
  logic [3:0]       sp_we;
  logic [31:0]      sp_din;
  logic [31:0]      sp_dout   = 32'd0;
`ifdef MMH_PERF_CNT_EN
  logic [31:0]      rsp_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mat_mul_host_seq #(
    .SYS_ARR_SIZE(SYS_ARR_SIZE),
    .DIM_W       (DIM_W),
    .POLL_GAP    (POLL_GAP),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ws_os (cmd_ws_os),
    .cmd_m     (cmd_m),
    .cmd_k     (cmd_k),
    .cmd_n     (cmd_n),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_status(rsp_status),
    .busy      (busy),
    .sp_addr   (sp_addr),
    .sp_en     (sp_en),
    .sp_we     (sp_we),
    .sp_din    (sp_din),
    .sp_dout   (sp_dout)
`ifdef MMH_PERF_CNT_EN
    ,
    .rsp_cycles(rsp_cycles)
`endif
  );

  // Scratchpad model with a done-word source that fires done_delay cycles after start.
  logic [31:0] mem [0:63] = '{default: 32'd0};
  logic [63:0] wr_log [$];
  logic [63:0] rd_log [$];
  int          cyc_cnt    = 0;
  int          start_cyc  = 0;
  int          done_cnt   = 0;
  int          done_delay = -1;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (sp_en && sp_we == 4'hF) begin
      mem[sp_addr[7:2]] <= sp_din;
      wr_log.push_back({sp_addr, sp_din});
      if (sp_addr == 32'h0 && sp_din == 32'd1) begin
        start_cyc <= cyc_cnt;
        if (done_delay == 0) mem[25] <= 32'd1;
        else if (done_delay > 0) done_cnt <= done_delay;
      end
    end else if (sp_en && sp_we == 4'h0) begin
      sp_dout <= mem[sp_addr[7:2]];
      rd_log.push_back({32'(cyc_cnt), sp_addr});
    end
    if (done_cnt > 0) begin
      done_cnt <= done_cnt - 1;
      if (done_cnt == 1) mem[25] <= 32'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete job: drive, observe, compare against the job-level model.
  task automatic run_job(input logic ws, input logic [DIM_W-1:0] m, input logic [DIM_W-1:0] k,
                         input logic [DIM_W-1:0] n, input int delay, input int bp);
    logic        legal;
    int          exp_status, t, exp_lat, lat, wb, rb, nw, nrd;
    logic        en_seen, hs_bad, wr_bad, rd_bad, stab_bad;
    logic [1:0]  st0;
    logic [63:0] exp_w [7];
    logic [63:0] r;
    legal = (m != 0) && (m <= SYS_ARR_SIZE) && (k != 0) && (k <= SYS_ARR_SIZE) &&
            (n != 0) && (n <= SYS_ARR_SIZE);
    t = 0;
    if (!legal) exp_status = 1;
    else if (delay < 0) exp_status = 2;
    else begin
      // Reads happen 1, 1+SPACING, ... cycles after start; a read sees done
      // only if done was raised strictly before it.
      t = 1;
      while (t <= delay) t += SPACING;
      exp_status = (t + 1 <= TIMEOUT_CYC) ? 0 : 2;
    end
    exp_lat = !legal ? 0 : ((exp_status == 0) ? 8 + t : TIMEOUT_CYC + 7);
    exp_w[0] = {32'h04, 31'd0, ws};
    exp_w[1] = {32'h08, 32'(m)};
    exp_w[2] = {32'h0C, 32'(k)};
    exp_w[3] = {32'h10, 32'(n)};
    exp_w[4] = {32'h00, 32'd1};
    exp_w[5] = {32'h00, 32'd0};
    exp_w[6] = {32'h64, 32'd0};
    nw = legal ? 7 : 0;

    done_delay = delay;
    wb = wr_log.size();
    rb = rd_log.size();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ws_os = ws; cmd_m = m; cmd_k = k; cmd_n = n;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    en_seen = sp_en;
    hs_bad = (cmd_ready !== 1'b0) || (busy !== 1'b1);
    while (rsp_valid !== 1'b1 && lat < 500) begin
      @(negedge clk);
      lat++;
      en_seen |= sp_en;
      hs_bad |= (cmd_ready !== 1'b0) || (busy !== 1'b1);
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_status", rsp_status, 64'(exp_status));
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_noready", hs_bad, 0);
    chk("wr_count", 64'(wr_log.size() - wb), 64'(nw));
    if (legal) begin
      wr_bad = 1'b0;
      for (int i = 0; i < 7; i++)
        if (wb + i >= wr_log.size() || wr_log[wb + i] !== exp_w[i]) wr_bad = 1'b1;
      chk("wr_seq", wr_bad, 0);
      rd_bad = (rd_log.size() == rb);
      for (int i = rb; i < rd_log.size(); i++) begin
        r = rd_log[i];
        if (r[31:0] !== 32'h64) rd_bad = 1'b1;
        if (i == rb && r[63:32] != 32'(start_cyc + 1)) rd_bad = 1'b1;
        if (i > rb && (r[63:32] - rd_log[i - 1][63:32]) != 32'(SPACING)) rd_bad = 1'b1;
      end
      chk("poll_pattern", rd_bad, 0);
      if (exp_status == 0) begin
        nrd = (t - 1) / SPACING + 1;
        chk("rd_count", 64'(rd_log.size() - rb), 64'(nrd));
      end
    end else begin
      chk("sp_en_quiet", en_seen, 0);
    end
`ifdef MMH_PERF_CNT_EN
    chk("rsp_cycles", rsp_cycles, (exp_status == 0) ? 64'(t + 2) : 64'd0);
`endif
    st0 = rsp_status;
    stab_bad = 1'b0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_status !== st0 || cmd_ready !== 1'b0 || busy !== 1'b1)
        stab_bad = 1'b1;
    end
    if (bp > 0) chk("bp_hold", stab_bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_release", {rsp_valid, cmd_ready, busy}, 3'b010);
  endtask

  initial begin
    logic [DIM_W-1:0] d [3];
    int dly;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {cmd_ready, busy, sp_en, rsp_valid, rsp_status}, 6'b100000);
    chk("rst_bus", {sp_addr, sp_din}, 64'd0);
    reset_n = 1'b1;

    run_job(1'b1, 8'd3, 8'd2, 8'd4, 20, 0);   // reference legal job
    run_job(1'b0, 8'd0, 8'd4, 8'd4, 5, 0);    // M = 0
    run_job(1'b1, 8'd4, 8'd4, 8'd9, 5, 0);    // N above the array edge
    run_job(1'b0, 8'd8, 8'd1, 8'd8, -1, 0);   // done never set
    run_job(1'b0, 8'd2, 8'd2, 8'd2, 0, 10);   // fastest job plus backpressure
    run_job(1'b1, 8'd1, 8'd8, 8'd1, 61, 2);   // done just too late

    // Async reset mid-job abandons it immediately.
    done_delay = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_m = 8'd2; cmd_k = 8'd2; cmd_n = 8'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_rst", {cmd_ready, busy, sp_en, rsp_valid}, 4'b1000);
    @(negedge clk);
    reset_n = 1'b1;

    for (int j = 0; j < 20; j++) begin
      for (int x = 0; x < 3; x++) begin
        if ($urandom_range(0, 7) == 0)
          d[x] = ($urandom_range(0, 1) == 0) ? 8'd0 : DIM_W'($urandom_range(SYS_ARR_SIZE + 1, 255));
        else
          d[x] = DIM_W'($urandom_range(1, SYS_ARR_SIZE));
      end
      dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 63));
      run_job(1'($urandom_range(0, 1)), d[0], d[1], d[2], dly, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
